// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaled timebase, edge/centre-aligned counting,
// per-channel polarity, and shadowed configuration that switches only at period start.
module pwm_multi_channel #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned PRE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [PRE_WIDTH-1:0]      prescale,
   input  logic [WIDTH-1:0]          period,
   input  logic [CHANNELS*WIDTH-1:0] duty,
   input  logic [CHANNELS-1:0]       polarity,
   input  logic                      center_mode,
   input  logic                      update_req,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic                      period_tick,
   output logic                      update_ack
);

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

   logic [PRE_WIDTH-1:0]      pre_q, pre_d;
   logic [WIDTH-1:0]          cnt_q, cnt_d;
   dir_e                      dir_q, dir_d;
   logic [WIDTH-1:0]          period_s_q, period_s_d;
   logic [CHANNELS*WIDTH-1:0] duty_s_q, duty_s_d;
   logic [CHANNELS-1:0]       pol_s_q, pol_s_d;
   logic                      center_s_q, center_s_d;
   logic                      pend_q, pend_d;
   logic [CHANNELS-1:0]       pwm_q, pwm_d;
   logic                      tick_out_q, ack_q;

   logic tick_c;
   logic boundary_c;
   logic load_c;

   // Timebase, boundary detection and shadow-load decision
   always_comb begin
      pre_d      = pre_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      period_s_d = period_s_q;
      duty_s_d   = duty_s_q;
      pol_s_d    = pol_s_q;
      center_s_d = center_s_q;
      pend_d     = pend_q;
      pwm_d      = '0;
      boundary_c = 1'b0;

      tick_c = enable && (pre_q == prescale);

      if (!center_s_q)
         boundary_c = tick_c && (cnt_q == period_s_q);
      else if (period_s_q == '0)
         boundary_c = tick_c;
      else
         boundary_c = tick_c && (dir_q == DIR_DOWN) && (cnt_q == WIDTH'(1));

      // While halted there is no boundary, so a request loads straight away
      load_c = enable ? (boundary_c && (pend_q || update_req)) : (pend_q || update_req);

      if (!enable) begin
         pre_d = '0;
         cnt_d = '0;
         dir_d = DIR_UP;
      end else begin
         pre_d = tick_c ? '0 : pre_q + PRE_WIDTH'(1);
         if (boundary_c) begin
            cnt_d = '0;
            dir_d = DIR_UP;
         end else if (tick_c) begin
            if (!center_s_q) begin
               cnt_d = cnt_q + WIDTH'(1);
            end else if (dir_q == DIR_UP) begin
               cnt_d = cnt_q + WIDTH'(1);
               // dir reflects the next step, so the peak value is already "down"
               if (cnt_d >= period_s_q) dir_d = DIR_DOWN;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end

      if (load_c) begin
         pend_d     = 1'b0;
         period_s_d = period;
         duty_s_d   = duty;
         pol_s_d    = polarity;
         center_s_d = center_mode;
      end else if (update_req) begin
         pend_d = 1'b1;
      end

      for (int k = 0; k < CHANNELS; k++) begin
         if (enable)
            pwm_d[k] = (cnt_q < duty_s_q[k*WIDTH +: WIDTH]) ^ pol_s_q[k];
         else
            pwm_d[k] = pol_s_q[k];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q      <= '0;
         cnt_q      <= '0;
         dir_q      <= DIR_UP;
         period_s_q <= '0;
         duty_s_q   <= '0;
         pol_s_q    <= '0;
         center_s_q <= 1'b0;
         pend_q     <= 1'b0;
         pwm_q      <= '0;
         tick_out_q <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         period_s_q <= period_s_d;
         duty_s_q   <= duty_s_d;
         pol_s_q    <= pol_s_d;
         center_s_q <= center_s_d;
         pend_q     <= pend_d;
         pwm_q      <= pwm_d;
         tick_out_q <= boundary_c;
         ack_q      <= load_c;
      end
   end

   assign pwm_out     = pwm_q;
   assign period_tick = tick_out_q;
   assign update_ack  = ack_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomized and directed bench for pwm_multi_channel against a phase-based reference model.
module tb_pwm_multi_channel;

   localparam int unsigned CH = 4;
   localparam int unsigned W  = 16;
   localparam int unsigned PW = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            enable = 1'b0;
   logic [PW-1:0]   prescale = '0;
   logic [W-1:0]    period = '0;
   logic [CH*W-1:0] duty = '0;
   logic [CH-1:0]   polarity = '0;
   logic            center_mode = 1'b0;
   logic            update_req = 1'b0;
   logic [CH-1:0]   pwm_out;
   logic            period_tick;
   logic            update_ack;

   always #5 clk = ~clk;

   pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .PRE_WIDTH(PW)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .prescale   (prescale),
      .period     (period),
      .duty       (duty),
      .polarity   (polarity),
      .center_mode(center_mode),
      .update_req (update_req),
      .pwm_out    (pwm_out),
      .period_tick(period_tick),
      .update_ack (update_ack)
   );

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: position within the period as a phase index, mapped to a counter value
   int          m_pre = 0;
   int          m_p = 0;
   int          m_per = 0;
   int          m_duty[CH] = '{default: 0};
   logic [CH-1:0] m_pol = '0;
   bit          m_cen = 1'b0;
   bit          m_pend = 1'b0;
   logic [CH-1:0] exp_pwm = '0;
   bit          exp_tick = 1'b0;
   bit          exp_ack = 1'b0;

   function automatic int m_len();
      if (m_cen) return (m_per == 0) ? 1 : 2 * m_per;
      return m_per + 1;
   endfunction

   function automatic int m_cnt(input int p);
      if (m_cen && p > m_per) return 2 * m_per - p;
      return p;
   endfunction

   always @(posedge clk or posedge reset) begin
      int cur;
      bit tk, bnd, ld;
      if (reset) begin
         m_pre = 0; m_p = 0; m_per = 0; m_pol = '0; m_cen = 1'b0; m_pend = 1'b0;
         for (int k = 0; k < CH; k++) m_duty[k] = 0;
         exp_pwm = '0; exp_tick = 1'b0; exp_ack = 1'b0;
      end else begin
         cur = m_cnt(m_p);
         ld  = 1'b0;
         if (!enable) begin
            exp_pwm  = m_pol;
            exp_tick = 1'b0;
            ld       = update_req || m_pend;
            m_pre    = 0;
            m_p      = 0;
         end else begin
            for (int k = 0; k < CH; k++) exp_pwm[k] = logic'(cur < m_duty[k]) ^ m_pol[k];
            tk    = (m_pre == int'(prescale));
            m_pre = tk ? 0 : m_pre + 1;
            bnd   = tk && (m_p == m_len() - 1);
            if (tk) m_p = bnd ? 0 : m_p + 1;
            exp_tick = bnd;
            ld       = bnd && (m_pend || update_req);
         end
         exp_ack = ld;
         if (ld) begin
            m_pend = 1'b0;
            m_per  = int'(period);
            for (int k = 0; k < CH; k++) m_duty[k] = int'(duty[k*W +: W]);
            m_pol  = polarity;
            m_cen  = center_mode;
         end else if (update_req) begin
            m_pend = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("pwm_out", 64'(pwm_out), 64'(exp_pwm));
         check("period_tick", 64'(period_tick), 64'(exp_tick));
         check("update_ack", 64'(update_ack), 64'(exp_ack));
      end
   end

   task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
      duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
   endtask

   // Pulse update_req and wait (bounded) for the acknowledge
   task automatic upd_wait(input string tag, input bit tick_align);
      bit seen = 1'b0;
      int n = 0;
      update_req = 1'b1;
      while (!seen && n < 3000) begin
         @(negedge clk);
         update_req = 1'b0;
         n++;
         if (update_ack) begin
            seen = 1'b1;
            if (tick_align) check({tag, "_tick_with_ack"}, 64'(period_tick), 64'd1);
         end
      end
      check({tag, "_ack_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic window(input int n, input int ch, input int exp_hi, input int exp_tk, input string tag);
      int hi = 0;
      int tk = 0;
      repeat (n) begin
         @(negedge clk);
         hi += int'(pwm_out[ch]);
         tk += int'(period_tick);
      end
      check({tag, "_high"}, 64'(hi), 64'(exp_hi));
      check({tag, "_ticks"}, 64'(tk), 64'(exp_tk));
   endtask

   initial begin
      bit found;
      int n;

      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pwm", 64'(pwm_out), 64'd0);
      check("rst_tick", 64'(period_tick), 64'd0);
      check("rst_ack", 64'(update_ack), 64'd0);
      reset = 1'b0;
      chk_on = 1'b1;

      // Edge mode, 10-cycle period, 3 cycles high
      prescale = 8'd0; period = 16'd9; set_duty(3, 0, 0, 0); polarity = '0; center_mode = 1'b0;
      upd_wait("t1_cfg", 1'b0);
      enable = 1'b1;
      repeat (5) @(negedge clk);
      window(100, 0, 30, 10, "t1");

      // Centre mode, period 8 -> 16 cycles; counter values 1,0,1 are below duty 2
      period = 16'd8; set_duty(3, 2, 0, 0); center_mode = 1'b1;
      upd_wait("t2_cfg", 1'b1);
      window(160, 1, 30, 10, "t2");

      // Prescaled edge mode: 20 clk period, 8 clk high; then duty 0
      enable = 1'b0; prescale = 8'd3; period = 16'd4; set_duty(2, 0, 0, 0); center_mode = 1'b0;
      upd_wait("t3_cfg", 1'b0);
      enable = 1'b1;
      window(100, 0, 40, 5, "t3");
      set_duty(0, 0, 0, 0);
      upd_wait("t3_zero", 1'b1);
      window(100, 0, 0, 5, "t3_zero");

      // Duty above period: constantly active, then inverted
      period = 16'd9; set_duty(10, 0, 0, 0);
      upd_wait("t4_full", 1'b1);
      window(120, 0, 120, 3, "t4_full");
      polarity = 4'b0001;
      upd_wait("t4_pol", 1'b1);
      window(120, 0, 0, 3, "t4_pol");

      // Mid-period update with new duty
      enable = 1'b0; prescale = 8'd0; period = 16'd9; set_duty(3, 0, 0, 0); polarity = '0;
      upd_wait("t5_cfg", 1'b0);
      enable = 1'b1;
      repeat (14) @(negedge clk);
      set_duty(7, 0, 0, 0);
      upd_wait("t5_mid", 1'b1);
      window(100, 0, 70, 10, "t5_new");

      // Async reset during a high pulse
      enable = 1'b0; set_duty(5, 0, 0, 0);
      upd_wait("t6_cfg", 1'b0);
      enable = 1'b1;
      found = 1'b0; n = 0;
      while (!found && n < 100) begin
         @(negedge clk);
         n++;
         if (exp_pwm[0]) found = 1'b1;
      end
      check("t6_high_found", 64'(found), 64'd1);
      #2 reset = 1'b1;
      #1 check("t6_async_rst", 64'(pwm_out), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Disabled outputs sit at polarity; re-enable starts a fresh period
      enable = 1'b0; polarity = 4'b1010;
      upd_wait("t6_pol", 1'b0);
      repeat (3) @(negedge clk);
      check("t6_dis_level", 64'(pwm_out), 64'(4'b1010));
      enable = 1'b1;
      @(negedge clk);
      check("t6_reen_first", 64'(pwm_out), 64'(4'b1011));
      window(100, 0, 50, 10, "t6_reen");

      // Randomized configurations and update timing
      for (int it = 0; it < 40; it++) begin
         bit dis;
         dis = ($urandom_range(0, 2) == 0);
         period = W'($urandom_range(0, 12));
         for (int k = 0; k < CH; k++) duty[k*W +: W] = W'($urandom_range(0, 14));
         polarity = CH'($urandom);
         center_mode = 1'($urandom_range(0, 1));
         if (dis) begin
            enable = 1'b0;
            prescale = PW'($urandom_range(0, 3));
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
            upd_wait("rnd_dis", 1'b0);
            enable = 1'b1;
         end else begin
            repeat (int'($urandom_range(0, 30))) @(negedge clk);
            upd_wait("rnd_upd", 1'b1);
            if ($urandom_range(0, 1) == 1) begin
               update_req = 1'b1;
               @(negedge clk);
               update_req = 1'b0;
            end
         end
         repeat (int'($urandom_range(20, 150))) @(negedge clk);
      end

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
